// File: rtl/puneh_mem_responder.sv
// Word memory behind a request/ready handshake with a fixed number of wait states.
// A separate program-load port writes the array directly, but only while idle.
module puneh_mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        readMEM,
  input  logic        writeMEM,
  input  logic [11:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rdy,
  output logic        busy,
  output logic        err,
  input  logic        ldEn,
  input  logic [11:0] ldAddr,
  input  logic [15:0] ldData
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [11:0] addr_q;
  logic [15:0] wdata_q;
  logic        op_write;
  logic        op_strobe;

  logic [15:0]      mem [DEPTH];
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [15:0]      mem_din;

  // Addresses beyond a reduced DEPTH fold back into the array.
  function automatic logic [IDX_W-1:0] wrap_addr(input logic [11:0] a);
    return IDX_W'(32'(a) % 32'(DEPTH));
  endfunction

  // The strobe of the op that was accepted must stay high through the wait phase.
  assign op_strobe = op_write ? writeMEM : readMEM;

  // Both write sources share a single array port. They never collide: a load
  // is only taken in IDLE, and a controller write only lands in DONE.
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = wrap_addr(addr_q);
    mem_din = wdata_q;
    if (!rst) begin
      if (state == IDLE && ldEn) begin
        mem_we  = 1'b1;
        mem_idx = wrap_addr(ldAddr);
        mem_din = ldData;
      end else if (state == DONE && op_write) begin
        mem_we = 1'b1;
      end
    end
  end

  // Array contents survive reset, so the array has no reset term.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_write <= 1'b0;
      rdata    <= '0;
      rdy      <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rdy <= 1'b0;
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          // A load takes the cycle. A request that is still held is picked up next cycle.
          if (!ldEn) begin
            if (readMEM && writeMEM) begin
              err <= 1'b1;
            end else if (readMEM || writeMEM) begin
              addr_q   <= addr;
              wdata_q  <= wdata;
              op_write <= writeMEM;
              busy     <= 1'b1;
              if (WAIT_CYCLES == 0) begin
                state    <= DONE;
                rdy      <= 1'b1;
                wait_cnt <= '0;
                if (!writeMEM) rdata <= mem[wrap_addr(addr)];
              end else begin
                state    <= WAIT;
                wait_cnt <= WAIT_INIT;
              end
            end
          end
        end
        WAIT: begin
          err <= ldEn;
          if (!op_strobe) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wait_cnt <= '0;
          end else if (wait_cnt <= 4'd1) begin
            // The final wait cycle: rdata is captured now so it is valid while rdy is high.
            state    <= DONE;
            rdy      <= 1'b1;
            wait_cnt <= '0;
            if (!op_write) rdata <= mem[wrap_addr(addr_q)];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          err   <= ldEn;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puneh_mem_responder.sv
// Scoreboard bench for puneh_mem_responder: a WAIT_CYCLES=2 full-depth instance (a)
// and a zero-wait 16-word instance (b), both driven with directed accesses.
`timescale 1ns/1ps
module tb_puneh_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        read_a, write_a, ld_en_a, rdy_a, busy_a, err_a;
  logic [11:0] addr_a, ld_addr_a;
  logic [15:0] wdata_a, ld_data_a, rdata_a;

  logic        read_b, write_b, ld_en_b, rdy_b, busy_b, err_b;
  logic [11:0] addr_b, ld_addr_b;
  logic [15:0] wdata_b, ld_data_b, rdata_b;

  always #5 clk = ~clk;

  puneh_mem_responder #(.WAIT_CYCLES(2), .DEPTH(4096)) dut_a (
    .clk(clk), .rst(rst), .readMEM(read_a), .writeMEM(write_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .rdy(rdy_a), .busy(busy_a), .err(err_a),
    .ldEn(ld_en_a), .ldAddr(ld_addr_a), .ldData(ld_data_a)
  );

  puneh_mem_responder #(.WAIT_CYCLES(0), .DEPTH(16)) dut_b (
    .clk(clk), .rst(rst), .readMEM(read_b), .writeMEM(write_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .rdy(rdy_b), .busy(busy_b), .err(err_b),
    .ldEn(ld_en_b), .ldAddr(ld_addr_b), .ldData(ld_data_b)
  );

  typedef struct packed {
    logic        is_read;
    logic [15:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t mon_a, mon_b;
  int n_compared = 0;
  int n_mismatched = 0;
  int err_seen_a = 0;
  int err_seen_b = 0;
  int err_expected_a = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every rdy pulse consumes one scoreboard entry; reads check rdata.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_a) err_seen_a++;
      if (err_b) err_seen_b++;
      if (rdy_a) begin
        if (q_a.size() == 0) check_output("unexpected_rdy_a", 32'(rdy_a), 32'd0);
        else begin
          mon_a = q_a.pop_front();
          if (mon_a.is_read) check_output("rdata_a", 32'(rdata_a), 32'(mon_a.data));
        end
      end
      if (rdy_b) begin
        if (q_b.size() == 0) check_output("unexpected_rdy_b", 32'(rdy_b), 32'd0);
        else begin
          mon_b = q_b.pop_front();
          if (mon_b.is_read) check_output("rdata_b", 32'(rdata_b), 32'(mon_b.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble(input bit sel);
    if (sel) begin
      addr_b  ^= 12'hFFF;
      wdata_b ^= 16'hFFFF;
    end else begin
      addr_a  ^= 12'hFFF;
      wdata_a ^= 16'hFFFF;
    end
  endtask

  // Counts cycles until rdy (k = -1 on timeout) and the busy cycles seen on the way.
  task automatic wait_rdy(input bit sel, input bit scr, output int k, output int busy_n);
    bit seen;
    seen = 0;
    k = 0;
    busy_n = 0;
    while (!seen && k < 20) begin
      tick();
      k++;
      if (sel ? busy_b : busy_a) busy_n++;
      if (sel ? rdy_b : rdy_a) seen = 1;
      if (scr && k == 1) scramble(sel);
    end
    if (!seen) k = -1;
  endtask

  task automatic apply_stimulus(input bit sel, input bit wr, input logic [11:0] a,
                                input logic [15:0] d, input logic [15:0] exp_data,
                                input int lat, input string name);
    int k, busy_n;
    if (sel) begin
      addr_b = a; wdata_b = d; write_b = wr; read_b = !wr;
      q_b.push_back('{!wr, exp_data});
    end else begin
      addr_a = a; wdata_a = d; write_a = wr; read_a = !wr;
      q_a.push_back('{!wr, exp_data});
    end
    wait_rdy(sel, 1'b1, k, busy_n);
    read_a = 0; write_a = 0; read_b = 0; write_b = 0;
    check_output({name, "_latency"}, 32'(k), 32'(lat));
    check_output({name, "_busy_cycles"}, 32'(busy_n), 32'(lat));
    tick();
    check_output({name, "_busy_after"}, 32'(sel ? busy_b : busy_a), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k, busy_n;
    read_a = 0; write_a = 0; ld_en_a = 0; addr_a = '0; wdata_a = '0; ld_addr_a = '0; ld_data_a = '0;
    read_b = 0; write_b = 0; ld_en_b = 0; addr_b = '0; wdata_b = '0; ld_addr_b = '0; ld_data_b = '0;
    rst = 1;
    tick();
    tick();
    check_output("reset_rdy_a",   32'(rdy_a),   32'd0);
    check_output("reset_busy_a",  32'(busy_a),  32'd0);
    check_output("reset_err_a",   32'(err_a),   32'd0);
    check_output("reset_rdata_a", 32'(rdata_a), 32'd0);
    check_output("reset_rdata_b", 32'(rdata_b), 32'd0);
    rst = 0;
    tick();

    // Program load, then a read through the handshake.
    ld_en_a = 1; ld_addr_a = 12'h010; ld_data_a = 16'hA5C3;
    tick();
    ld_en_a = 0;
    apply_stimulus(0, 0, 12'h010, 16'h0000, 16'hA5C3, 3, "load_read");

    apply_stimulus(0, 1, 12'h0FF, 16'h1234, 16'h0000, 3, "wr_0ff");
    apply_stimulus(0, 0, 12'h0FF, 16'h0000, 16'h1234, 3, "rd_0ff");
    apply_stimulus(0, 1, 12'h0FE, 16'h5678, 16'h0000, 3, "wr_0fe");
    apply_stimulus(0, 0, 12'h0FE, 16'h0000, 16'h5678, 3, "rd_0fe");

    // Conflicting strobes: err each cycle, nothing accepted.
    read_a = 1; write_a = 1; addr_a = 12'h0FF; wdata_a = 16'hDEAD;
    err_expected_a += 2;
    tick();
    check_output("both_err_1",  32'(err_a),  32'd1);
    check_output("both_busy_1", 32'(busy_a), 32'd0);
    tick();
    check_output("both_err_2",  32'(err_a),  32'd1);
    check_output("both_busy_2", 32'(busy_a), 32'd0);
    read_a = 0; write_a = 0;
    tick();
    check_output("both_err_clear", 32'(err_a), 32'd0);
    apply_stimulus(0, 0, 12'h0FF, 16'h0000, 16'h1234, 3, "both_unchanged");

    // Load attempted mid-access: err, no write.
    read_a = 1; addr_a = 12'h0FE;
    q_a.push_back('{1'b1, 16'h5678});
    tick();
    ld_en_a = 1; ld_addr_a = 12'h010; ld_data_a = 16'h0000;
    err_expected_a += 1;
    tick();
    ld_en_a = 0;
    wait_rdy(0, 1'b0, k, busy_n);
    read_a = 0;
    check_output("ld_in_wait_latency", 32'(k), 32'd1);
    tick();
    apply_stimulus(0, 0, 12'h010, 16'h0000, 16'hA5C3, 3, "ld_in_wait_ignored");

    // Load and read in the same idle cycle: load first, read accepted one cycle later.
    ld_en_a = 1; ld_addr_a = 12'h030; ld_data_a = 16'hC0DE;
    read_a = 1; addr_a = 12'h030;
    q_a.push_back('{1'b1, 16'hC0DE});
    tick();
    ld_en_a = 0;
    check_output("ld_prio_busy", 32'(busy_a), 32'd0);
    wait_rdy(0, 1'b0, k, busy_n);
    read_a = 0;
    check_output("ld_prio_latency", 32'(k), 32'd3);
    tick();

    // Write dropped during WAIT: aborted, old word kept.
    ld_en_a = 1; ld_addr_a = 12'h020; ld_data_a = 16'h0BEE;
    tick();
    ld_en_a = 0;
    write_a = 1; addr_a = 12'h020; wdata_a = 16'hFFFF;
    tick();
    check_output("abort_busy_accept", 32'(busy_a), 32'd1);
    write_a = 0;
    tick();
    check_output("abort_busy_drop", 32'(busy_a), 32'd0);
    tick();
    tick();
    apply_stimulus(0, 0, 12'h020, 16'h0000, 16'h0BEE, 3, "abort_read");

    // Reset in the middle of a write's wait phase.
    ld_en_a = 1; ld_addr_a = 12'h040; ld_data_a = 16'h1111;
    tick();
    ld_en_a = 0;
    write_a = 1; addr_a = 12'h040; wdata_a = 16'h2222;
    tick();
    tick();
    rst = 1;
    #1;
    check_output("rst_rdy",   32'(rdy_a),   32'd0);
    check_output("rst_busy",  32'(busy_a),  32'd0);
    check_output("rst_err",   32'(err_a),   32'd0);
    check_output("rst_rdata", 32'(rdata_a), 32'd0);
    write_a = 0;
    tick();
    rst = 0;
    tick();
    apply_stimulus(0, 0, 12'h040, 16'h0000, 16'h1111, 3, "rst_word_kept");

    // Zero-wait, 16-word instance: one-cycle latency and address folding.
    ld_en_b = 1; ld_addr_b = 12'h005; ld_data_b = 16'h5555;
    tick();
    ld_en_b = 0;
    apply_stimulus(1, 0, 12'h015, 16'h0000, 16'h5555, 1, "b_rd_wrap");
    apply_stimulus(1, 1, 12'h0FA, 16'h7777, 16'h0000, 1, "b_wr_wrap");
    apply_stimulus(1, 0, 12'h00A, 16'h0000, 16'h7777, 1, "b_rd_back");

    tick();
    tick();
    check_output("queue_a_drained", 32'(q_a.size()), 32'd0);
    check_output("queue_b_drained", 32'(q_b.size()), 32'd0);
    check_output("err_count_a", 32'(err_seen_a), 32'(err_expected_a));
    check_output("err_count_b", 32'(err_seen_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
